mux_sel_sequencer: RTL and testbench



---
 rtl/mux_seq_pkg.sv | 12 +
 rtl/mux_sel_counter.sv | 28 ++
 rtl/mux_sel_sequencer.sv | 116 +++++++++++
 tb/tb_mux_sel_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mux_seq_pkg.sv
// Shared state encoding and default mux geometry for the mux select sequencer
// and the 8:1 mux it drives.
package mux_seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_PAR   = 2'd2;

    localparam int MUX_WIDTH = 8;
    localparam int MUX_SEL_W = 3;

endpackage

// File: rtl/mux_sel_counter.sv
// Loadable up/down counter holding the mux select and the beat count.
// Load value and count direction are fixed by MSB_FIRST.
module mux_sel_counter #(
    parameter int SEL_W     = 3,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    output logic [SEL_W-1:0] sel,
    output logic [SEL_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel <= '0;
            cnt <= '0;
        end else if (load) begin
            sel <= (MSB_FIRST != 0) ? '1 : '0;
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
            sel <= (MSB_FIRST != 0) ? sel - 1'b1 : sel + 1'b1;
        end
    end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Parallel-to-serial front end for the 8:1 mux: holds a word on the mux data
// bus and steps its select. Optional trailing parity beat: MUX_SEQ_PARITY_EN.
//
// state    | meaning
// ST_IDLE  | ready for a new word, no serial output
// ST_SHIFT | stepping sel, mux_out forwarded as the serial bit
// ST_PAR   | even-parity beat after the data (MUX_SEQ_PARITY_EN only)
module mux_sel_sequencer
    import mux_seq_pkg::*;
#(
    parameter int WIDTH     = MUX_WIDTH,
    parameter int SEL_W     = MUX_SEL_W,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] mux_data,
    input  logic             mux_out,
    output logic             ser_valid,
    output logic             ser_data,
    output logic             ser_last,
    input  logic             ser_ready
);

    generate
        if (WIDTH != (1 << SEL_W)) begin : g_width_check
            $error("mux_sel_sequencer: WIDTH must equal 2**SEL_W");
        end
    endgenerate

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [SEL_W-1:0] cnt;
    logic             cnt_last;
    logic             do_load;
    logic             cnt_en;

    assign cnt_last = (cnt == SEL_W'(WIDTH - 1));
    assign do_load  = (state == ST_IDLE) && load_valid;
    // sel/cnt freeze on the last data beat so sel keeps its final index
    assign cnt_en   = (state == ST_SHIFT) && ser_ready && !cnt_last;

    mux_sel_counter #(
        .SEL_W     (SEL_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_counter (
        .clk  (clk),
        .rst  (rst),
        .load (do_load),
        .en   (cnt_en),
        .sel  (sel),
        .cnt  (cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            mux_data <= '0;
        end else begin
            state <= state_nxt;
            if (do_load)
                mux_data <= load_data;
        end
    end

`ifdef MUX_SEQ_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            parity_q <= 1'b0;
        else if (do_load)
            parity_q <= ^load_data;
    end

    assign ser_valid = (state == ST_SHIFT) || (state == ST_PAR);
    assign ser_data  = (state == ST_PAR) ? parity_q : mux_out;
    assign ser_last  = (state == ST_PAR);
`else
    assign ser_valid = (state == ST_SHIFT);
    assign ser_data  = mux_out;
    assign ser_last  = (state == ST_SHIFT) && cnt_last;
`endif

    assign load_ready = (state == ST_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (load_valid)
                    state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (ser_ready && cnt_last)
`ifdef MUX_SEQ_PARITY_EN
                    state_nxt = ST_PAR;
`else
                    state_nxt = ST_IDLE;
`endif
            end
`ifdef MUX_SEQ_PARITY_EN
            ST_PAR: begin
                if (ser_ready)
                    state_nxt = ST_IDLE;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Self-checking bench: an LSB-first and an MSB-first instance run in lockstep,
// each with a behavioural 8:1 mux on its select/data buses.
module tb_mux_sel_sequencer;

    localparam int W = 8;
`ifdef MUX_SEQ_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       ser_ready = 1'b0;

    logic       load_ready_l, load_ready_m;
    logic [2:0] sel_l, sel_m;
    logic [7:0] mux_data_l, mux_data_m;
    logic       mux_out_l, mux_out_m;
    logic       ser_valid_l, ser_valid_m;
    logic       ser_data_l, ser_data_m;
    logic       ser_last_l, ser_last_m;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign mux_out_l = mux_data_l[sel_l];
    assign mux_out_m = mux_data_m[sel_m];

    mux_sel_sequencer #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready_l), .sel(sel_l), .mux_data(mux_data_l),
        .mux_out(mux_out_l), .ser_valid(ser_valid_l), .ser_data(ser_data_l),
        .ser_last(ser_last_l), .ser_ready(ser_ready)
    );

    mux_sel_sequencer #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready_m), .sel(sel_m), .mux_data(mux_data_m),
        .mux_out(mux_out_m), .ser_valid(ser_valid_m), .ser_data(ser_data_m),
        .ser_last(ser_last_m), .ser_ready(ser_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream packed in beat order: bit 7 is the first beat.
    function automatic logic [7:0] model_stream(input logic [7:0] word, input bit msb_first);
        bit q[$];
        logic [7:0] s;
        for (int k = 0; k < W; k++)
            q.push_back(word[msb_first ? (W - 1 - k) : k]);
        for (int k = 0; k < W; k++)
            s[7 - k] = q[k];
        return s;
    endfunction

    function automatic logic model_parity(input logic [7:0] word);
        int ones = 0;
        for (int k = 0; k < W; k++)
            ones += int'(word[k]);
        return logic'(ones % 2);
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sel_l"}, 32'(sel_l), 0);
        chk({tag, "_sel_m"}, 32'(sel_m), 0);
        chk({tag, "_mux_data_l"}, 32'(mux_data_l), 0);
        chk({tag, "_mux_data_m"}, 32'(mux_data_m), 0);
        chk({tag, "_ser_valid"}, {30'd0, ser_valid_l, ser_valid_m}, 0);
        chk({tag, "_ser_last"}, {30'd0, ser_last_l, ser_last_m}, 0);
        chk({tag, "_load_ready"}, {30'd0, load_ready_l, load_ready_m}, 3);
    endtask

    task automatic run_frame(input logic [7:0] word, input logic [7:0] exp_l,
                             input logic [7:0] exp_m, input logic exp_p,
                             input int stall_at, input int stall_len, input bit rnd,
                             input bit busy, input int abort_at);
        int beat = 0;
        int cycles = 0;
        int stalls = 0;
        bit ready;
        logic exp_dl, exp_dm;
        @(negedge clk);
        chk("pre_load_ready", {30'd0, load_ready_l, load_ready_m}, 3);
        load_valid = 1'b1;
        load_data  = word;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        load_data  = 8'($urandom);
        while (beat < FRAME && cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (beat == abort_at) begin
                rst = 1'b1;
                #1;
                check_reset_outputs("abort");
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            exp_dl = (beat < W) ? exp_l[7 - beat] : exp_p;
            exp_dm = (beat < W) ? exp_m[7 - beat] : exp_p;
            chk("ser_valid", {30'd0, ser_valid_l, ser_valid_m}, 3);
            chk("load_ready_busy", {30'd0, load_ready_l, load_ready_m}, 0);
            chk("ser_data_l", 32'(ser_data_l), 32'(exp_dl));
            chk("ser_data_m", 32'(ser_data_m), 32'(exp_dm));
            chk("ser_last", {30'd0, ser_last_l, ser_last_m},
                (beat == FRAME - 1) ? 3 : 0);
            chk("sel_l", 32'(sel_l), (beat < W) ? beat : W - 1);
            chk("sel_m", 32'(sel_m), (beat < W) ? W - 1 - beat : 0);
            chk("mux_data", {16'd0, mux_data_l, mux_data_m}, {16'd0, word, word});
            if (beat == stall_at && stalls < stall_len) begin
                ready = 1'b0;
                stalls++;
            end else if (rnd) begin
                ready = ($urandom_range(0, 2) != 0);
            end else begin
                ready = 1'b1;
            end
            ser_ready  = ready;
            load_valid = busy && (beat == 2);
            load_data  = busy ? 8'hFF : load_data;
            if (ready)
                beat++;
            @(posedge clk);
            #1;
            load_valid = 1'b0;
        end
        if (cycles >= 200)
            chk("frame_timeout", 32'(beat), 32'(FRAME));
        @(negedge clk);
        chk("post_load_ready", {30'd0, load_ready_l, load_ready_m}, 3);
        chk("post_ser_valid", {30'd0, ser_valid_l, ser_valid_m}, 0);
    endtask

    typedef struct {
        logic [7:0] word;
        logic [7:0] exp_l;
        logic [7:0] exp_m;
        logic       exp_p;
        int         stall_at;
        int         stall_len;
        bit         busy;
        int         abort_at;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{8'b10101011, 8'b11010101, 8'b10101011, 1'b1, -1, 0, 1'b0, -1};
        vecs[1] = '{8'b10101011, 8'b11010101, 8'b10101011, 1'b1,  3, 4, 1'b0, -1};
        vecs[2] = '{8'b00001111, 8'b11110000, 8'b00001111, 1'b0, -1, 0, 1'b1, -1};
        vecs[3] = '{8'b10101011, 8'b11010101, 8'b10101011, 1'b1, -1, 0, 1'b0,  4};
        vecs[4] = '{8'b10100000, 8'b00000101, 8'b10100000, 1'b0, -1, 0, 1'b0, -1};
        vecs[5] = '{8'h00,       8'h00,       8'h00,       1'b0,  0, 2, 1'b0, -1};
        vecs[6] = '{8'hFF,       8'hFF,       8'hFF,       1'b0,  7, 3, 1'b1, -1};

        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ser_ready = 1'b1;

        for (int i = 0; i < 7; i++)
            run_frame(vecs[i].word, vecs[i].exp_l, vecs[i].exp_m, vecs[i].exp_p,
                      vecs[i].stall_at, vecs[i].stall_len, 1'b0, vecs[i].busy,
                      vecs[i].abort_at);

        for (int i = 0; i < 25; i++) begin
            logic [7:0] w;
            w = 8'($urandom);
            run_frame(w, model_stream(w, 1'b0), model_stream(w, 1'b1), model_parity(w),
                      -1, 0, 1'b1, ($urandom_range(0, 3) == 0), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
